// File: rtl/rcc_clk_div_pkg.sv
// rcc_clk_div_pkg: shared types, constants and the ratio-bus slicing helper
// for the multi-channel RCC clock divider.
package rcc_clk_div_pkg;

   // Per-channel divider state.
   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_RUN  = 2'd1,
      ST_PEND = 2'd2
   } ch_state_e;

   // Smallest ratio that produces a running clock; 0 and 1 mean "channel off".
   localparam int RATIO_MIN     = 2;

   // Upper bounds for the generic slicing helper.
   localparam int RATIO_MAX_WID = 16;
   localparam int BUS_MAX_WID   = 256;

   // Extract channel k's ratio field of width wid from a packed ratio bus.
   function automatic logic [RATIO_MAX_WID-1:0] ratio_slice(
      input logic [BUS_MAX_WID-1:0] bus,
      input int                     k,
      input int                     wid
   );
      logic [RATIO_MAX_WID-1:0] mask;
      mask = (RATIO_MAX_WID'(1) << wid) - RATIO_MAX_WID'(1);
      return RATIO_MAX_WID'(bus >> (k * wid)) & mask;
   endfunction

endpackage

// File: rtl/rcc_clk_div_ch.sv
// rcc_clk_div_ch: one divider channel. Synchronises the 4-phase update request,
// runs the OFF/RUN/PEND FSM, and produces the registered divided clock.
// Optional macro RCC_CLK_DIV_ODD50_EN adds a negedge flop giving 50% duty for odd ratios.
module rcc_clk_div_ch
   import rcc_clk_div_pkg::*;
#(
   parameter int RATIO_WID  = 6,
   parameter int SYNC_STAGE = 2
) (
   input  logic                 i_clk,
   input  logic                 rst_n,
   input  logic [RATIO_WID-1:0] ratio,
   input  logic                 upd_req,
   output logic                 upd_ack,
   output logic                 o_clk,
   output logic                 div_en
);

   logic [SYNC_STAGE-1:0] sync_q, sync_d;
   logic                  req_prev_q, req_prev_d;
   ch_state_e             state_q, state_d;
   logic [RATIO_WID-1:0]  act_q, act_d;
   logic [RATIO_WID-1:0]  pend_q, pend_d;
   logic [RATIO_WID-1:0]  cnt_q, cnt_d;
   logic                  ack_q, ack_d;
   logic                  pos_q, pos_d;
   logic                  en_q, en_d;
   logic                  req_s, req_edge, period_end, apply;

   // Next-state logic: request edge detection, counter, FSM and registered outputs.
   always_comb begin
      sync_d     = SYNC_STAGE'({sync_q, upd_req});
      req_s      = sync_q[SYNC_STAGE-1];
      req_prev_d = req_s;
      // Edges arriving while an update is still outstanding are protocol errors and dropped.
      req_edge   = req_s & ~req_prev_q & ~ack_q & (state_q != ST_PEND);
      // With no running ratio the "period" ends every cycle, so an update from OFF lands at once.
      period_end = (act_q < RATIO_WID'(RATIO_MIN)) || (cnt_q == act_q - RATIO_WID'(1));
      apply      = (state_q == ST_PEND) && period_end;

      state_d = state_q;
      act_d   = act_q;
      pend_d  = pend_q;
      cnt_d   = cnt_q;

      if (req_edge) begin
         pend_d = ratio;
      end

      if ((state_q != ST_OFF) && (act_q >= RATIO_WID'(RATIO_MIN))) begin
         cnt_d = (cnt_q == act_q - RATIO_WID'(1)) ? '0 : cnt_q + RATIO_WID'(1);
      end

      case (state_q)
         ST_OFF: begin
            if (req_edge) state_d = ST_PEND;
         end
         ST_RUN: begin
            if (req_edge) state_d = ST_PEND;
         end
         ST_PEND: begin
            if (apply) begin
               act_d   = pend_q;
               cnt_d   = '0;
               state_d = (pend_q >= RATIO_WID'(RATIO_MIN)) ? ST_RUN : ST_OFF;
            end
         end
         default: state_d = ST_OFF;
      endcase

      ack_d = apply | (ack_q & req_s);
      en_d  = (act_d >= RATIO_WID'(RATIO_MIN));
      pos_d = en_d && (cnt_d < (act_d >> 1));
   end

   // State and output registers, cleared immediately by the (synchronised-release) reset.
   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q     <= '0;
         req_prev_q <= 1'b0;
         state_q    <= ST_OFF;
         act_q      <= '0;
         pend_q     <= '0;
         cnt_q      <= '0;
         ack_q      <= 1'b0;
         pos_q      <= 1'b0;
         en_q       <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         req_prev_q <= req_prev_d;
         state_q    <= state_d;
         act_q      <= act_d;
         pend_q     <= pend_d;
         cnt_q      <= cnt_d;
         ack_q      <= ack_d;
         pos_q      <= pos_d;
         en_q       <= en_d;
      end
   end

   assign upd_ack = ack_q;
   assign div_en  = en_q;

`ifdef RCC_CLK_DIV_ODD50_EN
   logic neg_q, neg_d;

   // Half-cycle extension of the high phase, only for odd ratios.
   always_comb begin
      neg_d = pos_q & act_q[0];
   end

   // Falling-edge copy of the high phase.
   always_ff @(negedge i_clk or negedge rst_n) begin
      if (!rst_n) neg_q <= 1'b0;
      else        neg_q <= neg_d;
   end

   assign o_clk = pos_q | neg_q;
`else
   assign o_clk = pos_q;
`endif

endmodule

// File: rtl/rcc_clk_div_mc.sv
// rcc_clk_div_mc: CH_NUM independent glitch-free integer clock dividers sharing
// one source clock, with a shared reset-release synchroniser.
// Optional macro RCC_CLK_DIV_ODD50_EN (see rcc_clk_div_ch) gives 50% duty for odd ratios.
module rcc_clk_div_mc
   import rcc_clk_div_pkg::*;
#(
   parameter int CH_NUM     = 4,
   parameter int RATIO_WID  = 6,
   parameter int SYNC_STAGE = 2
) (
   input  logic                          i_clk,
   input  logic                          rst_n,
   input  logic                          testmode,
   input  logic [CH_NUM*RATIO_WID-1:0]   ratio,
   input  logic [CH_NUM-1:0]             upd_req,
   output logic [CH_NUM-1:0]             upd_ack,
   output logic [CH_NUM-1:0]             o_clk,
   output logic [CH_NUM-1:0]             div_en
);

   logic [SYNC_STAGE-1:0]   rst_sync_q, rst_sync_d;
   logic                    rst_int_n;
   logic [BUS_MAX_WID-1:0]  ratio_ext;

   // Reset synchroniser shift: assertion is immediate, release ripples through SYNC_STAGE flops.
   always_comb begin
      rst_sync_d = SYNC_STAGE'({rst_sync_q, 1'b1});
   end

   // Reset synchroniser flops.
   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) rst_sync_q <= '0;
      else        rst_sync_q <= rst_sync_d;
   end

   // DFT bypass lets scan control reset directly.
   assign rst_int_n = testmode ? rst_n : rst_sync_q[SYNC_STAGE-1];
   assign ratio_ext = BUS_MAX_WID'(ratio);

   for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
      logic [RATIO_WID-1:0] ch_ratio;
      assign ch_ratio = RATIO_WID'(ratio_slice(ratio_ext, k, RATIO_WID));

      rcc_clk_div_ch #(
         .RATIO_WID  (RATIO_WID),
         .SYNC_STAGE (SYNC_STAGE)
      ) u_ch (
         .i_clk   (i_clk),
         .rst_n   (rst_int_n),
         .ratio   (ch_ratio),
         .upd_req (upd_req[k]),
         .upd_ack (upd_ack[k]),
         .o_clk   (o_clk[k]),
         .div_en  (div_en[k])
      );
   end

endmodule

// File: tb/tb_rcc_clk_div_mc.sv
// tb_rcc_clk_div_mc: randomized self-checking bench for rcc_clk_div_mc with a
// period-arithmetic reference model of every channel.
`timescale 1ns/1ps
module tb_rcc_clk_div_mc;

   localparam int CH = 4;
   localparam int RW = 6;
   localparam int SS = 2;
`ifdef RCC_CLK_DIV_ODD50_EN
   localparam bit ODD50 = 1'b1;
`else
   localparam bit ODD50 = 1'b0;
`endif

   logic              clk      = 1'b0;
   logic              rst_n    = 1'b1;
   logic              testmode = 1'b0;
   logic [CH*RW-1:0]  ratio    = '0;
   logic [CH-1:0]     upd_req  = '0;
   logic [CH-1:0]     upd_ack, o_clk, div_en;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Reference model: active ratio and the cycle its current period train started.
   int            m_r[CH];
   int            m_t0[CH];
   int            m_pr[CH];
   int            m_apply[CH];
   bit            m_pend[CH];
   bit            m_ack[CH];
   bit            m_rsprev[CH];
   bit            m_ppos[CH];
   bit            m_podd[CH];
   logic [CH-1:0] m_hist[SS];
   int            m_hold = 0;
   logic [CH-1:0] e_o, e_en, e_ack;

   // Per-window mismatch record, inspected by the test tasks.
   int                mm_cnt  = 0;
   int                mm_cyc  = 0;
   logic [3*CH-1:0]   mm_got  = '0;
   logic [3*CH-1:0]   mm_want = '0;

   rcc_clk_div_mc #(.CH_NUM(CH), .RATIO_WID(RW), .SYNC_STAGE(SS)) dut (
      .i_clk    (clk),
      .rst_n    (rst_n),
      .testmode (testmode),
      .ratio    (ratio),
      .upd_req  (upd_req),
      .upd_ack  (upd_ack),
      .o_clk    (o_clk),
      .div_en   (div_en)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      for (int k = 0; k < CH; k++) begin
         m_r[k] = 0; m_t0[k] = 0; m_pr[k] = 0; m_apply[k] = 0;
         m_pend[k] = 0; m_ack[k] = 0; m_rsprev[k] = 0; m_ppos[k] = 0; m_podd[k] = 0;
      end
      for (int i = 0; i < SS; i++) m_hist[i] = '0;
   endfunction

   function automatic void model_step(input logic [CH-1:0] drv);
      logic [CH-1:0] rs;
      int            ph;
      bit            applied;
      bit            en, pos;
      if (!rst_n || m_hold > 0) begin
         if (!rst_n) m_hold = SS;
         else        m_hold--;
         model_reset();
      end else begin
         for (int i = SS-1; i > 0; i--) m_hist[i] = m_hist[i-1];
         m_hist[0] = drv;
         rs = m_hist[SS-1];
         for (int k = 0; k < CH; k++) begin
            applied = 0;
            if (m_pend[k] && cyc == m_apply[k] + 1) begin
               m_r[k] = m_pr[k]; m_t0[k] = cyc; m_pend[k] = 0; applied = 1;
            end
            m_ack[k] = applied | (m_ack[k] & m_rsprev[k]);
            if (rs[k] && !m_rsprev[k] && !m_ack[k] && !m_pend[k]) begin
               m_pend[k] = 1;
               m_pr[k]   = int'(ratio[k*RW +: RW]);
               if (m_r[k] < 2) m_apply[k] = cyc + 1;
               else begin
                  ph = (cyc - m_t0[k]) % m_r[k];
                  m_apply[k] = (ph == m_r[k]-1) ? cyc + m_r[k] : cyc + (m_r[k] - 1 - ph);
               end
            end
            m_rsprev[k] = rs[k];
         end
      end
      for (int k = 0; k < CH; k++) begin
         en  = (m_r[k] >= 2);
         pos = en && (((cyc - m_t0[k]) % m_r[k]) < (m_r[k] / 2));
         e_en[k]  = en;
         e_ack[k] = m_ack[k];
         e_o[k]   = pos | (ODD50 & m_ppos[k] & m_podd[k]);
         m_ppos[k] = pos;
         m_podd[k] = en && (m_r[k] % 2 == 1);
      end
   endfunction

   // Advance one clock, update the model, and record any output divergence.
   task automatic tick();
      logic [CH-1:0] drv;
      drv = upd_req;
      @(posedge clk);
      #1;
      cyc++;
      model_step(drv);
      if ({o_clk, div_en, upd_ack} !== {e_o, e_en, e_ack}) begin
         mm_cnt++;
         mm_cyc  = cyc;
         mm_got  = {o_clk, div_en, upd_ack};
         mm_want = {e_o, e_en, e_ack};
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Full 4-phase handshake on channel k driven from the model's acknowledge.
   task automatic hs(input int k, input int r, output bit ok);
      int n;
      ok = 1;
      ratio[k*RW +: RW] = RW'(r);
      upd_req[k] = 1'b1;
      n = 0;
      while (!m_ack[k] && n < 200) begin tick(); n++; end
      if (!m_ack[k]) ok = 0;
      upd_req[k] = 1'b0;
      n = 0;
      while (m_ack[k] && n < 20) begin tick(); n++; end
      if (m_ack[k]) ok = 0;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      #1;
      total++; if (o_clk !== '0)   begin bad++; $display("FAIL reset_o_clk got=%b want=0000", o_clk); end
      total++; if (div_en !== '0)  begin bad++; $display("FAIL reset_div_en got=%b want=0000", div_en); end
      total++; if (upd_ack !== '0) begin bad++; $display("FAIL reset_ack got=%b want=0000", upd_ack); end
      mm_cnt = 0;
      run(3);
      rst_n = 1'b1;
      run(6);
      total++; if (mm_cnt !== 0) begin bad++; $display("FAIL reset_window n=%0d cyc=%0d got=%h want=%h", mm_cnt, mm_cyc, mm_got, mm_want); end
      mm_cnt = 0;
   endtask

   task automatic test_single();
      int n, hi;
      ratio[0 +: RW] = RW'(4);
      upd_req[0] = 1'b1;
      n = 0;
      while (upd_ack[0] !== 1'b1 && n < 50) begin tick(); n++; end
      total++; if (n !== SS + 2) begin bad++; $display("FAIL ack_latency got=%0d want=%0d", n, SS + 2); end
      hi = 0;
      for (int i = 0; i < 4; i++) begin hi += int'(o_clk[0]); tick(); end
      total++; if (hi !== 2) begin bad++; $display("FAIL r4_high_cycles got=%0d want=2", hi); end
      total++; if (o_clk[0] !== 1'b1) begin bad++; $display("FAIL r4_period got=%b want=1", o_clk[0]); end
      total++; if (div_en !== 4'b0001) begin bad++; $display("FAIL r4_div_en got=%b want=0001", div_en); end
      total++; if (o_clk[3:1] !== 3'b000) begin bad++; $display("FAIL r4_others got=%b want=000", o_clk[3:1]); end
      upd_req[0] = 1'b0;
      run(6);
      total++; if (upd_ack[0] !== 1'b0) begin bad++; $display("FAIL r4_ack_clear got=%b want=0", upd_ack[0]); end
      total++; if (mm_cnt !== 0) begin bad++; $display("FAIL single_window n=%0d cyc=%0d got=%h want=%h", mm_cnt, mm_cyc, mm_got, mm_want); end
      mm_cnt = 0;
   endtask

   task automatic test_mid_update();
      bit ok1, ok2;
      hs(1, 5, ok1);
      run(int'($urandom_range(2, 6)));
      hs(1, 3, ok2);
      run(12);
      total++; if ({ok1, ok2} !== 2'b11) begin bad++; $display("FAIL mid_update_hs got=%b want=11", {ok1, ok2}); end
      total++; if (mm_cnt !== 0) begin bad++; $display("FAIL mid_update_window n=%0d cyc=%0d got=%h want=%h", mm_cnt, mm_cyc, mm_got, mm_want); end
      mm_cnt = 0;
   endtask

   task automatic test_off();
      bit ok1, ok2, ok3, ok4;
      hs(2, 6, ok1);
      run(4);
      hs(2, 1, ok2);
      run(8);
      total++; if ({o_clk[2], div_en[2]} !== 2'b00) begin bad++; $display("FAIL off_r1 got=%b want=00", {o_clk[2], div_en[2]}); end
      hs(2, 6, ok3);
      run(3);
      hs(2, 0, ok4);
      run(8);
      total++; if ({o_clk[2], div_en[2]} !== 2'b00) begin bad++; $display("FAIL off_r0 got=%b want=00", {o_clk[2], div_en[2]}); end
      total++; if ({ok1, ok2, ok3, ok4} !== 4'b1111) begin bad++; $display("FAIL off_hs got=%b want=1111", {ok1, ok2, ok3, ok4}); end
      total++; if (mm_cnt !== 0) begin bad++; $display("FAIL off_window n=%0d cyc=%0d got=%h want=%h", mm_cnt, mm_cyc, mm_got, mm_want); end
      mm_cnt = 0;
   endtask

   task automatic test_all_channels();
      int n;
      ratio   = {RW'(63), RW'(7), RW'(3), RW'(2)};
      upd_req = 4'b1111;
      n = 0;
      while (!(m_ack[0] && m_ack[1] && m_ack[2] && m_ack[3]) && n < 200) begin tick(); n++; end
      total++; if (n >= 200) begin bad++; $display("FAIL all_ack_timeout got=%0d want<200", n); end
      upd_req = 4'b0000;
      run(140);
      total++; if (div_en !== 4'b1111) begin bad++; $display("FAIL all_div_en got=%b want=1111", div_en); end
      total++; if (mm_cnt !== 0) begin bad++; $display("FAIL all_window n=%0d cyc=%0d got=%h want=%h", mm_cnt, mm_cyc, mm_got, mm_want); end
      mm_cnt = 0;
   endtask

   task automatic test_reset_mid_pend();
      bit ok;
      hs(0, 40, ok);
      run(3);
      ratio[0 +: RW] = RW'(5);
      upd_req[0] = 1'b1;
      run(SS + 3);
      #1;
      rst_n   = 1'b0;
      upd_req = '0;
      #1;
      total++; if ({o_clk, upd_ack, div_en} !== '0) begin bad++; $display("FAIL rst_mid_drop got=%b want=0", {o_clk, upd_ack, div_en}); end
      run(3);
      rst_n = 1'b1;
      run(20);
      total++; if ({o_clk, div_en} !== '0) begin bad++; $display("FAIL rst_mid_off got=%b want=0", {o_clk, div_en}); end
      total++; if (ok !== 1'b1) begin bad++; $display("FAIL rst_mid_hs got=%b want=1", ok); end
      total++; if (mm_cnt !== 0) begin bad++; $display("FAIL rst_mid_window n=%0d cyc=%0d got=%h want=%h", mm_cnt, mm_cyc, mm_got, mm_want); end
      mm_cnt = 0;
   endtask

   task automatic test_random();
      bit ok;
      int k, r;
      for (int it = 0; it < 10; it++) begin
         k = int'($urandom_range(0, CH-1));
         r = int'($urandom_range(0, 63));
         hs(k, r, ok);
         total++; if (ok !== 1'b1) begin bad++; $display("FAIL rand_hs ch=%0d r=%0d got=%b want=1", k, r, ok); end
         run(int'($urandom_range(0, 70)));
      end
      total++; if (mm_cnt !== 0) begin bad++; $display("FAIL rand_window n=%0d cyc=%0d got=%h want=%h", mm_cnt, mm_cyc, mm_got, mm_want); end
      mm_cnt = 0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_single();
      test_mid_update();
      test_off();
      test_all_channels();
      test_reset_mid_pend();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
